// File: rtl/ql_pkg.sv
// Shared Q-learning definitions: widths, saturation limits and the update FSM state type.
// Also used by the policy-generator side of the datapath.
package ql_pkg;
    localparam int STATE_W   = 4;
    localparam int N_STATES  = 16;
    localparam int N_ACTIONS = 4;
    localparam int Q_W       = 16;
    localparam int ROW_W     = N_ACTIONS * Q_W;

    localparam logic signed [Q_W-1:0] Q_MAX = 16'sh7FFF;
    localparam logic signed [Q_W-1:0] Q_MIN = 16'sh8000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_TD,
        ST_SCALE,
        ST_WRITE
    } ql_state_t;
endpackage

// File: rtl/qmax4.sv
// Combinational signed maximum of the four Q entries packed in one table row.
module qmax4
    import ql_pkg::*;
#(
    parameter int W = Q_W
)(
    input  logic [4*W-1:0]        row,
    output logic signed [W-1:0]   max_q
);
    logic signed [W-1:0] q0, q1, q2, q3, m01, m23;

    always_comb begin
        q0    = row[0*W +: W];
        q1    = row[1*W +: W];
        q2    = row[2*W +: W];
        q3    = row[3*W +: W];
        m01   = (q1 > q0) ? q1 : q0;
        m23   = (q3 > q2) ? q3 : q2;
        max_q = (m23 > m01) ? m23 : m01;
    end
endmodule

// File: rtl/q_updater.sv
// Q-table with a five-stage temporal-difference update engine and a registered read port
// feeding the policy generator.
//
// state    | meaning
// ST_IDLE  | wait for start; preloads accepted here
// ST_READ  | latch rows s and s' from the pre-update table
// ST_TD    | td = r + gamma*max(Q(s')) - Q(s,a)
// ST_SCALE | new = Q(s,a) + alpha*td, saturated to Q8.8
// ST_WRITE | write field a of row s, pulse done
module q_updater
    import ql_pkg::*;
#(
    parameter int N_STATES  = 16,
    parameter int N_ACTIONS = 4,
    parameter int Q_W       = 16
)(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [STATE_W-1:0]         rd_state,
    output logic [N_ACTIONS*Q_W-1:0]   q_values,
    input  logic                       start,
    input  logic [STATE_W-1:0]         cur_state,
    input  logic [N_ACTIONS-1:0]       action,
    input  logic [Q_W-1:0]             reward,
    input  logic [STATE_W-1:0]         next_state,
    input  logic [Q_W-1:0]             alpha,
    input  logic [Q_W-1:0]             gamma,
    input  logic                       init_we,
    input  logic [STATE_W-1:0]         init_state,
    input  logic [N_ACTIONS*Q_W-1:0]   init_row,
    output logic                       busy,
    output logic                       done,
    output logic                       sat,
    output logic                       act_err
);
    localparam int RW    = N_ACTIONS * Q_W;
    localparam int GM_W  = 2*Q_W + 1;
    localparam int TD_W  = 2*Q_W + 2;
    localparam int NEW_W = TD_W + Q_W + 1;

    logic [RW-1:0]           tbl [N_STATES];
    ql_state_t               st;
    logic [STATE_W-1:0]      s_r, ns_r;
    logic [N_ACTIONS-1:0]    a_r;
    logic signed [Q_W-1:0]   r_r;
    logic [Q_W-1:0]          alpha_r, gamma_r;
    logic [RW-1:0]           row_s, row_ns;
    logic signed [TD_W-1:0]  td_r;
    logic signed [Q_W-1:0]   new_r;
    logic                    sat_pend;

    logic signed [Q_W-1:0]   m_ns, q_sa, new_c;
    logic signed [GM_W-1:0]  gm;
    logic signed [TD_W-1:0]  td_c;
    logic signed [NEW_W-1:0] prod, new_x;
    logic                    sat_c, act_ok, wr_en;
    logic [STATE_W-1:0]      wr_idx;
    logic [RW-1:0]           wr_row;

    qmax4 #(.W(Q_W)) u_qmax4 (
        .row   (row_ns),
        .max_q (m_ns)
    );

    always_comb begin
        q_sa = '0;
        for (int k = 0; k < N_ACTIONS; k++)
            if (a_r[k]) q_sa = row_s[k*Q_W +: Q_W];

        gm   = GM_W'($signed({1'b0, gamma_r})) * GM_W'(m_ns);
        td_c = TD_W'(r_r) + TD_W'(gm >>> Q_W) - TD_W'(q_sa);

        // arithmetic shift gives floor division for negative td
        prod  = NEW_W'($signed({1'b0, alpha_r})) * NEW_W'(td_r);
        new_x = NEW_W'(q_sa) + (prod >>> Q_W);
        sat_c = 1'b0;
        new_c = new_x[Q_W-1:0];
        if (new_x > NEW_W'(Q_MAX)) begin
            new_c = Q_MAX;
            sat_c = 1'b1;
        end else if (new_x < NEW_W'(Q_MIN)) begin
            new_c = Q_MIN;
            sat_c = 1'b1;
        end

        act_ok = $onehot(action);

        wr_en  = 1'b0;
        wr_idx = s_r;
        wr_row = tbl[s_r];
        if (st == ST_WRITE) begin
            wr_en = 1'b1;
            for (int k = 0; k < N_ACTIONS; k++)
                if (a_r[k]) wr_row[k*Q_W +: Q_W] = new_r;
        end else if (st == ST_IDLE && init_we && !start) begin
            wr_en  = 1'b1;
            wr_idx = init_state;
            wr_row = init_row;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            sat      <= 1'b0;
            act_err  <= 1'b0;
            q_values <= '0;
            s_r      <= '0;
            ns_r     <= '0;
            a_r      <= '0;
            r_r      <= '0;
            alpha_r  <= '0;
            gamma_r  <= '0;
            row_s    <= '0;
            row_ns   <= '0;
            td_r     <= '0;
            new_r    <= '0;
            sat_pend <= 1'b0;
            for (int i = 0; i < N_STATES; i++) tbl[i] <= '0;
        end else begin
            done    <= 1'b0;
            sat     <= 1'b0;
            act_err <= 1'b0;
            if (wr_en) tbl[wr_idx] <= wr_row;
            // write-first so the policy stage never sees a stale row
            q_values <= (wr_en && wr_idx == rd_state) ? wr_row : tbl[rd_state];

            case (st)
                ST_IDLE: begin
                    if (start) begin
                        if (act_ok) begin
                            s_r     <= cur_state;
                            ns_r    <= next_state;
                            a_r     <= action;
                            r_r     <= reward;
                            alpha_r <= alpha;
                            gamma_r <= gamma;
                            busy    <= 1'b1;
                            st      <= ST_READ;
                        end else begin
                            act_err <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    row_s  <= tbl[s_r];
                    row_ns <= tbl[ns_r];
                    st     <= ST_TD;
                end
                ST_TD: begin
                    td_r <= td_c;
                    st   <= ST_SCALE;
                end
                ST_SCALE: begin
                    new_r    <= new_c;
                    sat_pend <= sat_c;
                    st       <= ST_WRITE;
                end
                ST_WRITE: begin
                    done <= 1'b1;
                    sat  <= sat_pend;
                    busy <= 1'b0;
                    st   <= ST_IDLE;
                end
                default: st <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_q_updater.sv
// Randomized and directed bench for q_updater against an integer-arithmetic Q-table model.
module tb_q_updater;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  rd_state;
    logic [63:0] q_values;
    logic        start;
    logic [3:0]  cur_state;
    logic [3:0]  action;
    logic [15:0] reward;
    logic [3:0]  next_state;
    logic [15:0] alpha;
    logic [15:0] gamma;
    logic        init_we;
    logic [3:0]  init_state;
    logic [63:0] init_row;
    logic        busy, done, sat, act_err;

    q_updater dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_state   (rd_state),
        .q_values   (q_values),
        .start      (start),
        .cur_state  (cur_state),
        .action     (action),
        .reward     (reward),
        .next_state (next_state),
        .alpha      (alpha),
        .gamma      (gamma),
        .init_we    (init_we),
        .init_state (init_state),
        .init_row   (init_row),
        .busy       (busy),
        .done       (done),
        .sat        (sat),
        .act_err    (act_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int qm [16][4];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] row_of(input int st);
        logic [63:0] v;
        for (int k = 0; k < 4; k++) v[16*k +: 16] = 16'(qm[st][k]);
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++)
            for (int k = 0; k < 4; k++) qm[i][k] = 0;
    endtask

    // Q(s,a) += alpha*(r + gamma*max Q(s') - Q(s,a)), floors on each /2^16, saturate
    task automatic model_update(input int s, input int aidx, input int r, input int ns,
                                input logic [15:0] al, input logic [15:0] ga, output bit sat_o);
        longint m, gmv, td, nv;
        m = qm[ns][0];
        for (int k = 1; k < 4; k++) if (qm[ns][k] > m) m = qm[ns][k];
        gmv = (longint'(ga) * m) >>> 16;
        td  = longint'(r) + gmv - longint'(qm[s][aidx]);
        nv  = longint'(qm[s][aidx]) + ((longint'(al) * td) >>> 16);
        sat_o = 1'b0;
        if (nv > 32767)  begin nv = 32767;  sat_o = 1'b1; end
        if (nv < -32768) begin nv = -32768; sat_o = 1'b1; end
        qm[s][aidx] = int'(nv);
    endtask

    task automatic preload(input logic [3:0] st, input logic [63:0] row);
        init_we    = 1'b1;
        init_state = st;
        init_row   = row;
        tick();
        init_we = 1'b0;
        for (int k = 0; k < 4; k++) qm[st][k] = int'($signed(row[16*k +: 16]));
    endtask

    task automatic run_update(input string tag, input logic [3:0] s, input logic [3:0] a,
                              input logic [15:0] r, input logic [3:0] ns,
                              input logic [15:0] al, input logic [15:0] ga, input bit full);
        bit exp_sat;
        int aidx;
        aidx = 0;
        for (int k = 0; k < 4; k++) if (a[k]) aidx = k;
        model_update(int'(s), aidx, int'($signed(r)), int'(ns), al, ga, exp_sat);
        cur_state  = s;
        action     = a;
        reward     = r;
        next_state = ns;
        alpha      = al;
        gamma      = ga;
        rd_state   = s;
        start      = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (full) begin
                chk({tag, "_busy"}, 64'(busy), 64'd1);
                chk({tag, "_nodone"}, 64'(done), 64'd0);
            end
            tick();
        end
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_busy_off"}, 64'(busy), 64'd0);
        chk({tag, "_sat"}, 64'(sat), 64'(exp_sat));
        chk({tag, "_row"}, q_values, row_of(int'(s)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; rd_state = 4'd3; start = 1'b0; cur_state = '0; action = '0;
        reward = '0; next_state = '0; alpha = '0; gamma = '0;
        init_we = 1'b0; init_state = '0; init_row = '0;
        model_clear();
        #12;
        chk("rst_qv", q_values, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_acterr", 64'(act_err), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // first edge after release must accept start
        run_update("basic", 4'd3, 4'b0001, 16'h0100, 4'd5, 16'h8000, 16'hE666, 1'b1);
        chk("basic_f0", 64'(q_values[15:0]), 64'h0080);

        preload(4'd5, {4{16'h7FFF}});
        preload(4'd2, 64'h0000_0000_7000_0000);
        run_update("satur", 4'd2, 4'b0010, 16'h7FFF, 4'd5, 16'hFFFF, 16'hFFFF, 1'b1);
        chk("satur_f1", 64'(q_values[31:16]), 64'h7FFF);
        chk("satur_flag", 64'(sat), 64'd1);

        run_update("neg", 4'd4, 4'b1000, 16'hFF00, 4'd4, 16'h8000, 16'hE666, 1'b1);
        chk("neg_f3", 64'(q_values[63:48]), 64'hFF80);

        // bad action
        rd_state = 4'd3;
        cur_state = 4'd3; action = 4'b0110; reward = 16'h0400; next_state = 4'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("acterr_pulse", 64'(act_err), 64'd1);
        chk("acterr_busy", 64'(busy), 64'd0);
        tick();
        chk("acterr_clear", 64'(act_err), 64'd0);
        chk("acterr_busy2", 64'(busy), 64'd0);
        chk("acterr_tbl", q_values, row_of(3));

        // preload alongside start and during busy is dropped
        init_we = 1'b1; init_state = 4'd9; init_row = 64'h1234_5678_9ABC_DEF0;
        run_update("initblk", 4'd6, 4'b0100, 16'h0200, 4'd2, 16'h4000, 16'h8000, 1'b0);
        init_we = 1'b0;
        rd_state = 4'd9;
        tick();
        chk("initblk_row9", q_values, row_of(9));

        // start held high: accepted only from IDLE, every 5 cycles
        begin
            bit s1, s2;
            model_update(7, 2, 300, 7, 16'hC000, 16'h9000, s1);
            model_update(7, 2, 300, 7, 16'hC000, 16'h9000, s2);
            cur_state = 4'd7; action = 4'b0100; reward = 16'd300; next_state = 4'd7;
            alpha = 16'hC000; gamma = 16'h9000; rd_state = 4'd7;
            start = 1'b1;
            for (int i = 1; i <= 10; i++) begin
                tick();
                chk($sformatf("hold_done%0d", i), 64'(done), 64'(i == 5 || i == 10));
            end
            start = 1'b0;
            tick();
            chk("hold_idle", 64'(busy), 64'd0);
            chk("hold_row", q_values, row_of(7));
        end

        // reset while in SCALE
        cur_state = 4'd3; action = 4'b0001; reward = 16'h0300; next_state = 4'd2;
        alpha = 16'hFFFF; gamma = 16'h8000; rd_state = 4'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_sat", 64'(sat), 64'd0);
        chk("abort_qv", q_values, 64'd0);
        #3 rst_n = 1'b1;
        model_clear();
        tick();
        chk("abort_row3", q_values, 64'd0);

        for (int it = 0; it < 30; it++) begin
            logic [3:0] s, ns;
            if ($urandom_range(0, 2) == 0)
                preload(4'($urandom_range(0, 15)), {$urandom(), $urandom()});
            s  = 4'($urandom_range(0, 15));
            ns = ($urandom_range(0, 3) == 0) ? s : 4'($urandom_range(0, 15));
            run_update($sformatf("rnd%0d", it), s, 4'(1 << $urandom_range(0, 3)),
                       16'($urandom()), ns, 16'($urandom()), 16'($urandom()), 1'b0);
            rd_state = 4'($urandom_range(0, 15));
            tick();
            chk($sformatf("rnd%0d_rd", it), q_values, row_of(int'(rd_state)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/q_updater.md
Q_UPDATER -- requirements
Module: q_updater

Interface
REQ-001 Parameter N_STATES, default 16: Q-table rows; state index width STATE_W = 4.
REQ-002 Parameter N_ACTIONS, default 4: Q values per row; one-hot action width.
REQ-003 Parameter Q_W, default 16: signed Q8.8 Q-value and reward width; row width ROW_W = N_ACTIONS*Q_W = 64.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port rd_state, input, 4: row to present on q_values.
REQ-007 Port q_values, output, 64: registered row rd_state; action k occupies bits [16k+15:16k]; this is the Q-value feed to the downstream policy-generator stage.
REQ-008 Port start, input, 1: update request; sampled only in IDLE.
REQ-009 Port cur_state, input, 4: s.
REQ-010 Port action, input, 4: one-hot a, as issued by the policy stage.
REQ-011 Port reward, input, 16: signed Q8.8 r.
REQ-012 Port next_state, input, 4: s'.
REQ-013 Port alpha, input, 16: unsigned Q0.16 learning rate.
REQ-014 Port gamma, input, 16: unsigned Q0.16 discount factor.
REQ-015 Port init_we, input, 1: table preload strobe; honoured only in IDLE with start low.
REQ-016 Port init_state, input, 4: preload row index.
REQ-017 Port init_row, input, 64: preload data.
REQ-018 Port busy, output, 1: high while an update is in flight.
REQ-019 Port done, output, 1: one-cycle pulse on write-back.
REQ-020 Port sat, output, 1: qualified by done; high if the result was clamped.
REQ-021 Port act_err, output, 1: one-cycle pulse when start is rejected because action is not one-hot.

Function
REQ-022 FSM states: IDLE, READ, TD, SCALE, WRITE; the FSM advances one state per clock.
REQ-023 IDLE: start with one-hot action latches s, a, r, s', alpha and gamma, then moves to READ; start with non-one-hot action stays in IDLE and pulses act_err on the next cycle.
REQ-024 READ latches row s and row s' from the pre-update table; this applies when s == s'.
REQ-025 TD computes m = max over the four signed entries of row s', then td = r + floor(gamma*m / 2^16) - Q(s,a); td is carried at 34-bit signed width so it cannot overflow.
REQ-026 SCALE computes delta = floor(alpha*td / 2^16) using an arithmetic shift, and new = Q(s,a) + delta.
REQ-027 SCALE clamps new to the range [-32768, 32767] and records sat.
REQ-028 WRITE replaces only action a's field of row s; the following edge returns the FSM to IDLE.
REQ-029 Latency: start sampled at edge E0 -> table updated at edge E4; done=1 and busy=0 in the cycle after E4.
REQ-030 busy is 1 in the cycles after E0 through E3.
REQ-031 start while busy is ignored, with no queuing.
REQ-032 start is accepted in the cycle done is high.
REQ-033 q_values has 1-cycle registered latency from rd_state.
REQ-034 Write-first: when a write-back or preload hits the row being read at the same edge, q_values shows the new data.
REQ-035 init_we while busy, or together with start, is ignored; in that case start wins.

Reset
REQ-036 rst_n low asynchronously clears: every table row to 0, q_values to 0, FSM to IDLE, and busy, done, sat and act_err to 0.
REQ-037 Reset mid-update aborts the update with no partial write; the table is zero after release.
REQ-038 The first start is honoured at the first rising edge after rst_n rises.

Structure
REQ-039 Shared package ql_pkg holds STATE_W, N_ACTIONS, Q_W, ROW_W, Q_MAX/Q_MIN constants and the FSM state enum type; PolicyGenerator-side blocks reuse it.
REQ-040 One sub-module, qmax4: combinational signed maximum of four Q_W entries, instantiated in the TD stage.
REQ-041 The table is 16x64 register storage with one write port and two internal read ports plus the q_values port.

Verification
REQ-042 After reset: rd_state=3 -> q_values=0; start with s=3, a=0001, r=0x0100, s'=5, alpha=0x8000, gamma=0xE666 -> done at E4+1, row 3 field0=0x0080, sat=0.
REQ-043 Preload row 5 with all fields 0x7FFF and row 2 field1 with 0x7000; start s=2, a=0010, r=0x7FFF, s'=5, alpha=gamma=0xFFFF -> field1=0x7FFF, sat=1.
REQ-044 Negative path: row 4 = 0; start s=4, a=1000, r=0xFF00 (-1.0), s'=4, alpha=0x8000 -> field3=0xFF80 (-0.5).
REQ-045 start with action=0110 -> act_err pulses once, busy stays 0, table unchanged; start asserted every cycle -> updates accepted only at IDLE edges (every 5 cycles).
REQ-046 rst_n pulsed low in the SCALE state -> all outputs 0 immediately, q_values for the target row 0 after release.
REQ-047 rd_state equal to s during WRITE -> q_values shows the updated row on the edge after E4.
